// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Routes one inbound valid/ready stream to one of two outbound streams (A or B)
// according to a per-word select bit. Each destination owns a small FIFO, so a
// stalled consumer only holds back words that are addressed to it. Words
// delivered on each destination are counted by a free-running 8-bit counter.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst          : synchronous active-high reset
//   src_data     : inbound word
//   src_sel      : destination select, 0 -> A, 1 -> B
//   src_valid    : inbound word and select are valid
//   src_ready    : selected destination buffer can take a word this cycle
//   dsta_data    : head word of buffer A (zero when A is empty)
//   dsta_valid   : buffer A holds at least one word
//   dsta_ready   : consumer A takes the head word
//   dstb_*       : same as dsta_* for buffer B
//   cnta / cntb  : words delivered on A / B, wrapping at 256
//
// Parameters
//   WIDTH : data word width in bits
//   DEPTH : entries per destination buffer, power of two from 2 to 16
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// stream_demux_fifo
//
// Single-clock FIFO used for each destination. Pointers carry one extra bit
// beyond the address so that full and empty can be told apart when the
// address bits match.
//
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   wr_en_i    : write request (ignored while full)
//   wr_data_i  : word to write
//   rd_en_i    : read request (ignored while empty)
//   rd_data_o  : head word, zero while empty
//   full_o     : all DEPTH entries occupied
//   empty_o    : no entries occupied
// -----------------------------------------------------------------------------
module stream_demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t             wr_ptr_q;
  ptr_t             wr_ptr_d;
  ptr_t             rd_ptr_q;
  ptr_t             rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  // Same address bits with differing wrap bits means the writer is exactly one
  // lap ahead of the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // what is visible, and an unreset array maps onto plain RAM/flops cheaply.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Zero while empty so stale storage never leaks onto the output bus.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

module stream_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_sel,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [WIDTH-1:0] dsta_data,
  output logic             dsta_valid,
  input  logic             dsta_ready,
  output logic [WIDTH-1:0] dstb_data,
  output logic             dstb_valid,
  input  logic             dstb_ready,
  output logic [7:0]       cnta,
  output logic [7:0]       cntb
);

  logic       a_full;
  logic       a_empty;
  logic       b_full;
  logic       b_empty;
  logic       src_fire;
  logic       a_wr;
  logic       b_wr;
  logic       a_rd;
  logic       b_rd;
  logic [7:0] cnta_q;
  logic [7:0] cnta_d;
  logic [7:0] cntb_q;
  logic [7:0] cntb_d;

  // Ready depends only on the addressed buffer, never on src_valid, and never
  // on a same-cycle read: a full buffer frees its slot one edge later.
  assign src_ready = src_sel ? !b_full : !a_full;
  assign src_fire  = src_valid && src_ready;
  assign a_wr      = src_fire && !src_sel;
  assign b_wr      = src_fire &&  src_sel;

  assign dsta_valid = !a_empty;
  assign dstb_valid = !b_empty;
  assign a_rd       = dsta_valid && dsta_ready;
  assign b_rd       = dstb_valid && dstb_ready;

  stream_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (a_wr),
    .wr_data_i (src_data),
    .rd_en_i   (a_rd),
    .rd_data_o (dsta_data),
    .full_o    (a_full),
    .empty_o   (a_empty)
  );

  stream_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (b_wr),
    .wr_data_i (src_data),
    .rd_en_i   (b_rd),
    .rd_data_o (dstb_data),
    .full_o    (b_full),
    .empty_o   (b_empty)
  );

  // Delivery counters wrap naturally at 8 bits.
  always_comb begin
    cnta_d = cnta_q;
    cntb_d = cntb_q;
    if (a_rd) begin
      cnta_d = cnta_q + 8'd1;
    end
    if (b_rd) begin
      cntb_d = cntb_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnta_q <= 8'd0;
      cntb_q <= 8'd0;
    end else begin
      cnta_q <= cnta_d;
      cntb_q <= cntb_d;
    end
  end

  assign cnta = cnta_q;
  assign cntb = cntb_q;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Directed bench for stream_demux (WIDTH=8, DEPTH=4). A table of per-cycle
// input/expected-output records covers routing, fill/stall, destination
// independence, full-with-read, read-while-empty and reset mid-stream. Longer
// sequences (concurrent read/write, pointer wrap) use a small queue model.
// Outputs are sampled 1 ns after the falling edge, inputs driven on it.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] src_data;
  logic             src_sel;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] dsta_data;
  logic             dsta_valid;
  logic             dsta_ready;
  logic [WIDTH-1:0] dstb_data;
  logic             dstb_valid;
  logic             dstb_ready;
  logic [7:0]       cnta;
  logic [7:0]       cntb;

  stream_demux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dsta_data  (dsta_data),
    .dsta_valid (dsta_valid),
    .dsta_ready (dsta_ready),
    .dstb_data  (dstb_data),
    .dstb_valid (dstb_valid),
    .dstb_ready (dstb_ready),
    .cnta       (cnta),
    .cntb       (cntb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One record = inputs held for one cycle plus outputs expected just before
  // the rising edge at which those inputs take effect.
  typedef struct {
    logic       rst;
    logic [7:0] data;
    logic       sel;
    logic       valid;
    logic       rdy_a;
    logic       rdy_b;
    logic       exp_sr;
    logic       exp_av;
    logic [7:0] exp_ad;
    logic       exp_bv;
    logic [7:0] exp_bd;
    logic [7:0] exp_ca;
    logic [7:0] exp_cb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] d, input logic s, input logic v,
                     input logic ra, input logic rb, input logic sr, input logic av,
                     input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                     input logic [7:0] ca, input logic [7:0] cb);
    vec_t t;
    t.rst = r;  t.data = d;  t.sel = s;  t.valid = v;  t.rdy_a = ra;  t.rdy_b = rb;
    t.exp_sr = sr;  t.exp_av = av;  t.exp_ad = ad;  t.exp_bv = bv;  t.exp_bd = bd;
    t.exp_ca = ca;  t.exp_cb = cb;
    vecs.push_back(t);
  endtask

  // Reference model for the hand-written sequences.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ma;
  logic [7:0] mb;

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;  src_valid = 1'b0;  dsta_ready = 1'b0;  dstb_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    qa.delete();  qb.delete();  ma = 8'd0;  mb = 8'd0;
  endtask

  task automatic step(input logic [7:0] d, input logic s, input logic v,
                      input logic ra, input logic rb, input string tag);
    logic exp_sr;
    logic acc;
    logic rda;
    logic rdb;
    @(negedge clk);
    src_data = d;  src_sel = s;  src_valid = v;  dsta_ready = ra;  dstb_ready = rb;
    #1;
    exp_sr = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    check({tag, " src_ready"},  src_ready,  exp_sr);
    check({tag, " dsta_valid"}, dsta_valid, qa.size() != 0);
    check({tag, " dsta_data"},  dsta_data,  (qa.size() != 0) ? qa[0] : 8'h00);
    check({tag, " dstb_valid"}, dstb_valid, qb.size() != 0);
    check({tag, " dstb_data"},  dstb_data,  (qb.size() != 0) ? qb[0] : 8'h00);
    check({tag, " cnta"}, cnta, ma);
    check({tag, " cntb"}, cntb, mb);
    acc = v && exp_sr;
    rda = ra && (qa.size() != 0);
    rdb = rb && (qb.size() != 0);
    @(posedge clk);
    if (rda) begin void'(qa.pop_front()); ma = ma + 8'd1; end
    if (rdb) begin void'(qb.pop_front()); mb = mb + 8'd1; end
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;  src_data = '0;  src_sel = 1'b0;  src_valid = 1'b0;
    dsta_ready = 1'b0;  dstb_ready = 1'b0;
    ma = 8'd0;  mb = 8'd0;

    //  rst data   sel v ra rb | sr av ad     bv bd     ca     cb
    // Routing
    add(0, 8'h11, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(0, 8'h22, 1, 1, 1, 1,   1, 1, 8'h11, 0, 8'h00, 8'd0, 8'd0);
    add(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 1, 8'h22, 8'd1, 8'd0);
    add(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd1, 8'd1);
    // Fill A with the consumer stalled; fifth word refused
    add(0, 8'h01, 0, 1, 0, 1,   1, 0, 8'h00, 0, 8'h00, 8'd1, 8'd1);
    add(0, 8'h02, 0, 1, 0, 1,   1, 1, 8'h01, 0, 8'h00, 8'd1, 8'd1);
    add(0, 8'h03, 0, 1, 0, 1,   1, 1, 8'h01, 0, 8'h00, 8'd1, 8'd1);
    add(0, 8'h04, 0, 1, 0, 1,   1, 1, 8'h01, 0, 8'h00, 8'd1, 8'd1);
    add(0, 8'h05, 0, 1, 0, 1,   0, 1, 8'h01, 0, 8'h00, 8'd1, 8'd1);
    // A full and stalled: B still accepts
    add(0, 8'hAB, 1, 1, 0, 0,   1, 1, 8'h01, 0, 8'h00, 8'd1, 8'd1);
    add(0, 8'h05, 0, 1, 0, 0,   0, 1, 8'h01, 1, 8'hAB, 8'd1, 8'd1);
    // Full A with consumer ready: no same-cycle accept, accept next cycle
    add(0, 8'h05, 0, 1, 1, 0,   0, 1, 8'h01, 1, 8'hAB, 8'd1, 8'd1);
    add(0, 8'h05, 0, 1, 1, 0,   1, 1, 8'h02, 1, 8'hAB, 8'd2, 8'd1);
    // Drain both
    add(0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h03, 1, 8'hAB, 8'd3, 8'd1);
    add(0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h04, 0, 8'h00, 8'd4, 8'd2);
    add(0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h05, 0, 8'h00, 8'd5, 8'd2);
    add(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd6, 8'd2);
    // Write and ready on an empty buffer: write only
    add(0, 8'h5A, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd6, 8'd2);
    add(0, 8'h00, 0, 0, 0, 0,   1, 1, 8'h5A, 0, 8'h00, 8'd6, 8'd2);
    // Three words buffered in A, then reset with handshakes pending
    add(0, 8'h61, 0, 1, 0, 0,   1, 1, 8'h5A, 0, 8'h00, 8'd6, 8'd2);
    add(0, 8'h62, 0, 1, 0, 0,   1, 1, 8'h5A, 0, 8'h00, 8'd6, 8'd2);
    add(1, 8'h63, 0, 1, 1, 1,   1, 1, 8'h5A, 0, 8'h00, 8'd6, 8'd2);
    add(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(0, 8'h77, 1, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 1, 8'h77, 8'd0, 8'd0);
    add(0, 8'h00, 1, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd1);

    // Initial reset, then check the post-reset state for both selects.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    src_sel = 1'b1;
    #1;
    check("reset src_ready sel=1", src_ready, 1'b1);
    check("reset dstb_valid", dstb_valid, 1'b0);
    check("reset dstb_data", dstb_data, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;  src_data = vecs[i].data;  src_sel = vecs[i].sel;
      src_valid = vecs[i].valid;  dsta_ready = vecs[i].rdy_a;  dstb_ready = vecs[i].rdy_b;
      #1;
      check($sformatf("vec%0d src_ready", i),  src_ready,  vecs[i].exp_sr);
      check($sformatf("vec%0d dsta_valid", i), dsta_valid, vecs[i].exp_av);
      check($sformatf("vec%0d dsta_data", i),  dsta_data,  vecs[i].exp_ad);
      check($sformatf("vec%0d dstb_valid", i), dstb_valid, vecs[i].exp_bv);
      check($sformatf("vec%0d dstb_data", i),  dstb_data,  vecs[i].exp_bd);
      check($sformatf("vec%0d cnta", i), cnta, vecs[i].exp_ca);
      check($sformatf("vec%0d cntb", i), cntb, vecs[i].exp_cb);
      @(posedge clk);
    end

    // Concurrent: A half-full, 20 cycles of simultaneous write and read.
    reset_dut();
    step(8'h30, 1'b0, 1'b1, 1'b0, 1'b0, "conc fill0");
    step(8'h31, 1'b0, 1'b1, 1'b0, 1'b0, "conc fill1");
    for (int i = 0; i < 20; i++) begin
      step(8'h40 + 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("conc%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("conc drain%0d", i));
    end
    @(negedge clk);
    #1;
    check("conc final cnta", cnta, 8'd22);
    check("conc final dsta_valid", dsta_valid, 1'b0);

    // Wrap: 260 words to B, consumer always ready.
    reset_dut();
    for (int i = 0; i < 260; i++) begin
      step(8'(i) ^ 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, $sformatf("wrap%0d", i));
    end
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "wrap drain");
    @(negedge clk);
    #1;
    check("wrap final cntb", cntb, 8'd4);
    check("wrap final dstb_valid", dstb_valid, 1'b0);
    check("wrap final cnta", cnta, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per output buffer; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port src_data, input, WIDTH, inbound word.
REQ-006 SHALL have port src_sel, input, 1, destination select: 0 routes to port A, 1 routes to port B.
REQ-007 SHALL have port src_valid, input, 1, inbound word and select are valid.
REQ-008 SHALL have port src_ready, output, 1, block accepts the inbound word this cycle.
REQ-009 SHALL have ports dsta_data, output, WIDTH and dstb_data, output, WIDTH, head words of buffers A and B.
REQ-010 SHALL have ports dsta_valid, output, 1 and dstb_valid, output, 1, head word present.
REQ-011 SHALL have ports dsta_ready, input, 1 and dstb_ready, input, 1, consumer takes head word.
REQ-012 SHALL have ports cnta, output, 8 and cntb, output, 8, words delivered on A and B.

Function
REQ-013 Input handshake: word accepted on a rising edge where src_valid=1 and src_ready=1.
REQ-014 src_ready SHALL equal "buffer selected by src_sel not full"; it is combinational on src_sel, independent of src_valid.
REQ-015 Accepted word SHALL be written only to the buffer selected by src_sel; the other buffer is unaffected.
REQ-016 Each buffer is a DEPTH-entry FIFO with write/read pointers of log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-017 dstX_valid SHALL be 1 exactly when buffer X is non-empty; dstX_data = buffer X head when valid, all-zeros when empty.
REQ-018 Output handshake: head of X removed on a rising edge where dstX_valid=1 and dstX_ready=1; dstX_ready while empty has no effect.
REQ-019 Latency: word accepted at edge N into an empty buffer SHALL show dstX_valid=1 and the word after edge N (one cycle); no combinational src-to-dst path.
REQ-020 Order SHALL be preserved per destination; no ordering relation across A and B.
REQ-021 Simultaneous write and read on a non-full, non-empty buffer: occupancy unchanged, both complete.
REQ-022 Simultaneous write and read on an empty buffer: no read occurs (valid was 0); write completes; occupancy becomes 1.
REQ-023 Full buffer with dstX_ready=1: src_ready stays 0 that cycle (no same-cycle pass-through); read completes; accept possible next cycle.
REQ-024 Pointers SHALL wrap modulo 2*DEPTH without loss or duplication.
REQ-025 A and B SHALL operate concurrently; a stalled destination blocks only inbound words selecting it.
REQ-026 cntX SHALL increment by 1 on each output handshake on X, wrapping 255 to 0.
REQ-027 src_sel and src_data SHALL be sampled only at an accepting edge; changes while src_ready=0 are legal.

Reset
REQ-028 When rst=1 at a rising edge, both buffers SHALL become empty, pointers 0, cnta=cntb=0.
REQ-029 After reset: dsta_valid=dstb_valid=0, dsta_data=dstb_data=0, src_ready=1 for either src_sel.
REQ-030 Reset mid-operation SHALL discard all buffered words and ignore handshakes in the reset cycle.
REQ-031 While rst=1, src_ready is a don't-care for the source; no word is accepted.

Verification
REQ-032 Route: after reset, send 0x11 sel=0 then 0x22 sel=1, both ready=1 -> dsta 0x11 one cycle after acceptance, dstb 0x22 likewise; cnta=cntb=1.
REQ-033 Fill: DEPTH=4, dsta_ready=0, send 0x01..0x05 sel=0 -> 4 accepted, src_ready=0 on 5th; raise dsta_ready -> 0x01..0x05 in order; cnta=5.
REQ-034 Independence: A full and stalled, send 0xAB sel=1 -> accepted immediately, dstb_data=0xAB next cycle, A contents unchanged.
REQ-035 Concurrent: A half-full, continuous write sel=0 with dsta_ready=1 for 20 cycles -> occupancy constant, 20 words in order, no loss.
REQ-036 Wrap: 260 words to B, always ready -> cntb=4, all data in order through multiple pointer wraps.
REQ-037 Reset mid-stream: 3 words buffered in A, assert rst one cycle -> dsta_valid=0, cnta=0, src_ready=1; old words never appear.
